sme_param_engine: RTL

//  Parametrised string-match engine: next generation of the SME block. Streams in one string and
//  any number of patterns, one char/cycle. After each pattern, reports one match/no-match result

---
 rtl/sme_param_engine_if.sv | 24 ++
 rtl/sme_param_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_param_engine_if.sv
// Char stream and result bundle of the string-match engine.
// The producer drives master; the engine is the slave.
interface sme_param_engine_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
);
  logic [DATA_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  logic              ovf;

  modport master (
    output chardata, isstring, ispattern,
    input  valid, match, match_index, ovf
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output valid, match, match_index, ovf
  );
endinterface

// File: rtl/sme_param_engine.sv
// String-match engine: stores a string, scans each pattern, reports first match.
// Define SME_STAR_EN for the single '*' wildcard (adds the SCAN2 state).
module sme_param_engine #(
  parameter int DATA_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic clk,
  input  logic reset,
  sme_param_engine_if.slave bus
);

  localparam int LW = IDX_W + 1;
  localparam int PI = $clog2(PAT_MAX);
  localparam int PW = $clog2(PAT_MAX + 1);
  localparam int PD = 1 << PI;
  localparam int CW = LW + PW + 1;

  localparam logic [DATA_W-1:0] C_SP     = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] C_DOLLAR = DATA_W'(8'h24);
  localparam logic [DATA_W-1:0] C_DOT    = DATA_W'(8'h2E);
  localparam logic [DATA_W-1:0] C_CARET  = DATA_W'(8'h5E);
`ifdef SME_STAR_EN
  localparam logic [DATA_W-1:0] C_STAR   = DATA_W'(8'h2A);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_STR,
    LOAD_PAT,
    SCAN,
`ifdef SME_STAR_EN
    SCAN2,
`endif
    DONE
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] str_q [STR_MAX];
  logic [DATA_W-1:0] pat_q [PD];
  logic [LW-1:0]     slen_q;
  logic [PW-1:0]     plen_q;
  logic [LW-1:0]     s_q;
  logic [PW-1:0]     j_q;
  logic              valid_q;
  logic              match_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ovf_q;
`ifdef SME_STAR_EN
  logic [IDX_W-1:0]  base_q;
  logic              has_star;
  logic [PW-1:0]     star_p;
`endif

  logic              str_we, pat_we;
  logic [IDX_W-1:0]  str_wa;
  logic [PI-1:0]     pat_wa;
  logic              anc_s, anc_e, sa, ea;
  logic [PW-1:0]     b0, bend, seg_lo, seg_len;
  logic [DATA_W-1:0] pc, sc, prev_c, next_c;
  logic [CW-1:0]     seg_end;
  logic              beyond, start_ok, end_ok, eq, last;
  logic              st_miss, st_hit, st_step;

  always_comb begin
    str_we = 1'b0;
    pat_we = 1'b0;
    str_wa = '0;
    pat_wa = '0;
    unique case (state_q)
      IDLE: begin
        str_we = bus.isstring;
        pat_we = !bus.isstring && bus.ispattern;
      end
      DONE: str_we = bus.isstring;
      LOAD_STR: begin
        str_we = bus.isstring && (slen_q < LW'(STR_MAX));
        str_wa = IDX_W'(slen_q);
        pat_we = !bus.isstring && bus.ispattern;
      end
      LOAD_PAT: begin
        pat_we = bus.ispattern && (plen_q < PW'(PAT_MAX));
        pat_wa = PI'(plen_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (str_we) str_q[str_wa] <= bus.chardata;
    if (pat_we) pat_q[pat_wa] <= bus.chardata;
  end

  // Anchors are stripped off; the scanned body is pattern[b0 .. bend-1].
  always_comb begin
    anc_s = (pat_q[0] == C_CARET);
    anc_e = (plen_q > PW'(anc_s)) &&
            (pat_q[PI'(plen_q - PW'(1))] == C_DOLLAR);
    b0    = PW'(anc_s);
    bend  = plen_q - PW'(anc_e);
`ifdef SME_STAR_EN
    has_star = 1'b0;
    star_p   = '0;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (!has_star && PW'(k) >= b0 && PW'(k) < bend &&
          pat_q[k] == C_STAR) begin
        has_star = 1'b1;
        star_p   = PW'(k);
      end
    end
    if (state_q == SCAN2) begin
      seg_lo  = star_p + PW'(1);
      seg_len = bend - star_p - PW'(1);
      sa      = 1'b0;
      ea      = anc_e;
    end else begin
      seg_lo  = b0;
      seg_len = has_star ? star_p - b0 : bend - b0;
      sa      = anc_s;
      ea      = anc_e && !has_star;
    end
`else
    seg_lo  = b0;
    seg_len = bend - b0;
    sa      = anc_s;
    ea      = anc_e;
`endif
  end

  always_comb begin
    pc       = pat_q[PI'(seg_lo + j_q)];
    sc       = str_q[IDX_W'(s_q + LW'(j_q))];
    seg_end  = CW'(s_q) + CW'(seg_len);
    beyond   = seg_end > CW'(slen_q);
    prev_c   = str_q[IDX_W'(s_q - LW'(1))];
    next_c   = str_q[IDX_W'(seg_end)];
    start_ok = !sa || (s_q == '0) || (prev_c == C_SP);
    end_ok   = !ea || (seg_end == CW'(slen_q)) || (next_c == C_SP);
    eq       = (pc == C_DOT) || (pc == sc);
    last     = (j_q == seg_len - PW'(1));
    st_miss  = (slen_q == '0) || beyond;
    st_hit   = !st_miss &&
               ((seg_len == '0) || (start_ok && eq && last && end_ok));
    st_step  = start_ok && eq && !last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slen_q  <= '0;
      plen_q  <= '0;
      s_q     <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef SME_STAR_EN
      base_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.isstring) begin
            slen_q  <= LW'(1);
            ovf_q   <= 1'b0;
            state_q <= LOAD_STR;
          end else if (state_q == IDLE && bus.ispattern) begin
            plen_q  <= PW'(1);
            ovf_q   <= 1'b0;
            state_q <= LOAD_PAT;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD_STR: begin
          if (bus.isstring) begin
            if (slen_q < LW'(STR_MAX)) slen_q <= slen_q + LW'(1);
            else ovf_q <= 1'b1;
          end else if (bus.ispattern) begin
            plen_q  <= PW'(1);
            ovf_q   <= 1'b0;
            state_q <= LOAD_PAT;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD_PAT: begin
          if (bus.ispattern) begin
            if (plen_q < PW'(PAT_MAX)) plen_q <= plen_q + PW'(1);
            else ovf_q <= 1'b1;
          end else begin
            s_q     <= '0;
            j_q     <= '0;
            state_q <= SCAN;
          end
        end
`ifdef SME_STAR_EN
        SCAN, SCAN2: begin
`else
        SCAN: begin
`endif
          if (st_miss) begin
            valid_q <= 1'b1;
            match_q <= 1'b0;
            idx_q   <= '0;
            state_q <= DONE;
          end else if (st_hit) begin
`ifdef SME_STAR_EN
            // Prefix found: suffix search starts right after it.
            if (state_q == SCAN && has_star) begin
              base_q  <= IDX_W'(s_q);
              s_q     <= s_q + LW'(seg_len);
              j_q     <= '0;
              state_q <= SCAN2;
            end else begin
              valid_q <= 1'b1;
              match_q <= 1'b1;
              idx_q   <= (state_q == SCAN2) ? base_q : IDX_W'(s_q);
              state_q <= DONE;
            end
`else
            valid_q <= 1'b1;
            match_q <= 1'b1;
            idx_q   <= IDX_W'(s_q);
            state_q <= DONE;
`endif
          end else if (st_step) begin
            j_q <= j_q + PW'(1);
          end else begin
            s_q <= s_q + LW'(1);
            j_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.valid       = valid_q;
  assign bus.match       = match_q;
  assign bus.match_index = idx_q;
  assign bus.ovf         = ovf_q;

endmodule
